// File: rtl/circular_deque.sv
// circular_deque: double-ended circular store with registered read path and status.
// Optional build macro CIRCULAR_DEQUE_OVERWRITE_EN: a push at full evicts the opposite end.
module circular_deque #(
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned CAPACITY        = 64,
    parameter int unsigned ALMOST_FULL_TH  = CAPACITY - 2,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           push_front,
    input  logic [WORD_SIZE-1:0]           data_in,
    input  logic                           pop,
    input  logic                           pop_back,
    output logic [WORD_SIZE-1:0]           data_out,
    output logic                           data_valid,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [$clog2(CAPACITY+1)-1:0]  level,
    output logic                           overflow,
    output logic                           underflow
);
    localparam int unsigned AW = $clog2(CAPACITY);
    localparam int unsigned LW = $clog2(CAPACITY + 1);
    localparam logic [AW-1:0] LAST  = AW'(CAPACITY - 1);
    localparam logic [LW-1:0] CAP_L = LW'(CAPACITY);

    logic [WORD_SIZE-1:0] mem [CAPACITY];

    logic [AW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [LW-1:0]        level_q, level_d;
    logic [WORD_SIZE-1:0] data_out_q;
    logic                 data_valid_q, full_q, empty_q, almost_full_q, almost_empty_q;
    logic                 overflow_q, underflow_q;

    logic                 pop_ok, push_ok, evict, at_full, overflow_d, underflow_d, wr_en;
    logic [AW-1:0]        rd_addr, wr_addr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return (p == '0) ? LAST : p - AW'(1);
    endfunction

    // Pop, eviction and push are applied in sequence to intermediate pointers, so
    // same-end push+pop nets out to an in-place overwrite of the popped slot.
    always_comb begin
        at_full     = (level_q == CAP_L);
        pop_ok      = pop && (level_q != '0);
`ifdef CIRCULAR_DEQUE_OVERWRITE_EN
        push_ok     = push;
        evict       = push && at_full && !pop_ok;
`else
        push_ok     = push && (!at_full || pop_ok);
        evict       = 1'b0;
`endif
        overflow_d  = push && at_full && !pop_ok;
        underflow_d = pop && !pop_ok;

        head_d  = head_q;
        tail_d  = tail_q;
        rd_addr = head_q;
        wr_addr = tail_q;
        wr_en   = 1'b0;

        if (pop_ok) begin
            if (pop_back) begin
                tail_d  = ptr_dec(tail_q);
                rd_addr = tail_d;
            end else begin
                rd_addr = head_q;
                head_d  = ptr_inc(head_q);
            end
        end

        if (evict) begin
            if (push_front) tail_d = ptr_dec(tail_d);
            else            head_d = ptr_inc(head_d);
        end

        if (push_ok) begin
            wr_en = 1'b1;
            if (push_front) begin
                head_d  = ptr_dec(head_d);
                wr_addr = head_d;
            end else begin
                wr_addr = tail_d;
                tail_d  = ptr_inc(tail_d);
            end
        end

        level_d = level_q;
        case ({push_ok && !evict, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_addr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            level_q        <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_full_q  <= (ALMOST_FULL_TH == 0);
            almost_empty_q <= 1'b1;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            level_q        <= level_d;
            data_valid_q   <= pop_ok;
            if (pop_ok) data_out_q <= mem[rd_addr];
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            empty_q        <= (level_d == '0);
            full_q         <= (level_d == CAP_L);
            almost_full_q  <= (32'(level_d) >= ALMOST_FULL_TH);
            almost_empty_q <= (32'(level_d) <= ALMOST_EMPTY_TH);
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: doc/circular_deque.md
Name: circular_deque

Overview:
Parametrised successor to the team's single-port circular buffer. It is a double-ended circular store: words can be pushed or popped at either end, so one block serves as FIFO, LIFO or deque.
- Full/empty/level are exact across the whole capacity.
- Same-cycle push and pop are defined.
- Overflow and underflow are flagged.
- Registered read path with a valid strobe.
It sits between producer/consumer stages in the datapath.

Parameters:
- WORD_SIZE, 32, data word width in bits.
- CAPACITY, 64, number of storage words; any integer >= 2, power of two not required.
- ALMOST_FULL_TH, CAPACITY-2, almost_full asserts when level >= this value.
- ALMOST_EMPTY_TH, 2, almost_empty asserts when level <= this value.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  write request.
- push_front  input  1  0 = push at back (tail), 1 = push at front (head); sampled with push.
- data_in  input  WORD_SIZE  write data.
- pop  input  1  read request.
- pop_back  input  1  0 = pop from front (head), 1 = pop from back (tail); sampled with pop.
- data_out  output  WORD_SIZE  popped word, registered.
- data_valid  output  1  one-cycle strobe: data_out updated this cycle.
- full  output  1  level == CAPACITY.
- empty  output  1  level == 0.
- almost_full  output  1  level >= ALMOST_FULL_TH.
- almost_empty  output  1  level <= ALMOST_EMPTY_TH.
- level  output  $clog2(CAPACITY+1)  current occupancy.
- overflow  output  1  one-cycle pulse: a push was rejected or lost data.
- underflow  output  1  one-cycle pulse: a pop was rejected.

Behaviour:
Reset and storage
- Reset (rst=1 at a clock edge) wins over all requests.
- Reset values: head=0, tail=0, level=0, data_out=0, data_valid=0, overflow=0, underflow=0, empty=1, full=0.
- almost_empty and almost_full reset to their values at level 0.
- Memory contents are not cleared on reset.
- Reset mid-operation discards all contents; requests in the reset cycle are ignored.

Pointers
- head indexes the front element; tail indexes the next free back slot.
- All pointer arithmetic is modulo CAPACITY, with explicit wrap: CAPACITY-1 +1 -> 0 and 0 -1 -> CAPACITY-1.
- Back push: write mem[tail], then tail+1.
- Front push: head-1, then write mem[head-1].
- Front pop: read mem[head], then head+1.
- Back pop: read mem[tail-1], then tail-1.

Read timing
- 1-cycle pop latency: an accepted pop at edge N gives data_out/data_valid valid after edge N.
- data_out holds its value until the next accepted pop.

Acceptance rules (evaluated on pre-edge level)
- A pop is accepted iff level > 0. Otherwise it is rejected and underflow pulses.
- A push is accepted iff level < CAPACITY, or if a pop is accepted in the same cycle. Otherwise it is rejected, overflow pulses and the memory is unchanged.
- An empty deque with push+pop: the pop is rejected (underflow=1), the push is accepted, and level becomes 1. There is no bypass.

Simultaneous accepted push+pop
- Level is unchanged.
- The pop always returns the pre-edge element.
- Same end (push front + pop front, or push back + pop back): the popped slot is overwritten with data_in and the pointer is net unchanged.
- Opposite ends: both pointers move as described.

Status outputs
- Status flags and level are registered and reflect post-edge occupancy in the same cycle as the level update.
- No combinational path exists from inputs to outputs.

Optional Feature:
Macro: CIRCULAR_DEQUE_OVERWRITE_EN.
- Defined: a push at full with no accepted pop is accepted and the element at the opposite end is evicted.
  - A back push drops the front: head+1, then write.
  - A front push drops the back: tail-1, then write.
  - level stays CAPACITY and overflow still pulses to mark the loss.
- Undefined: a push at full is rejected as described above.

Test Plan:
1. Reset, then 64 back pushes of 0..63 -> full=1, level=64, almost_full=1 from level 62. A 65th push -> overflow=1 for one cycle and level stays 64. (Overwrite build: front becomes 1.)
2. 64 front pops after scenario 1 -> data_out 0..63 in order with data_valid each cycle after the pop, and empty=1 at the end. A further pop -> underflow=1 and data_out holds 63.
3. Push back 0xA, 0xB, 0xC, then three back pops -> 0xC, 0xB, 0xA (LIFO). Push front 0x1, push back 0x2, pop back -> 0x2, pop front -> 0x1.
4. Wrap: 60 pushes, 60 pops, then 10 pushes -> pointers wrap past 63 to 0. The next 10 front pops return data in push order and level returns to 0.
5. At full, push back 0x55 + pop front in the same cycle -> old front returned, level stays 64 and no overflow. At empty, push+pop -> underflow=1 and level=1.
6. Reset asserted with level=5 and push=1 -> level=0, empty=1, data_valid=0, and the push is ignored.
